// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module : instr_fetch_pkg
// Brief  : Shared state encoding and instruction-field constants for instr_fetch
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_HOLD = 2'd2;
    localparam fetch_state_t ST_ERR  = 2'd3;

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 21;
    localparam int INSTR_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_next_pc.sv
// ============================================================================
// Module : next_pc_calc
// Brief  : Combinational next-PC select: word-scaled branch target or pc+4
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module next_pc_calc
    import instr_fetch_pkg::*;
(
    input  logic [63:0] pc_i,
    input  logic [63:0] signext_imm_i,
    input  logic        branch_i,
    input  logic        uncond_branch_i,
    input  logic        zero_i,
    output logic [63:0] next_pc_o
);

    logic        w_taken;
    logic [63:0] w_offset;

    // Unknown control values fall through to the sequential path.
    assign w_taken   = (uncond_branch_i === 1'b1) ||
                       ((branch_i === 1'b1) && (zero_i === 1'b1));
    assign w_offset  = w_taken ? (signext_imm_i << 2) : 64'(INSTR_BYTES);
    assign next_pc_o = pc_i + w_offset;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module : instr_fetch
// Brief  : PC holder and req/ack instruction fetcher with timeout error trap.
//          Optional perf counters enabled by macro INSTR_FETCH_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [10:0] opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        uncond_branch,
    input  logic        zero,
    input  logic [63:0] signext_imm,
    output logic [63:0] pc,
    output logic        fetch_err
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  tmo_q, tmo_d;
    logic [63:0]  w_next_pc;

    next_pc_calc u_next_pc (
        .pc_i            (pc_q),
        .signext_imm_i   (signext_imm),
        .branch_i        (branch),
        .uncond_branch_i (uncond_branch),
        .zero_i          (zero),
        .next_pc_o       (w_next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                tmo_d   = 32'd0;
            end
            ST_REQ: begin
                // Ack takes priority over an expiring timeout in the same cycle.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                    tmo_d   = 32'd0;
                end else if ((TIMEOUT != 0) && (tmo_q == TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_d    = w_next_pc;
                    state_d = ST_REQ;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            tmo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign instr_valid = (state_q == ST_HOLD);
    assign fetch_err   = (state_q == ST_ERR);

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             w_retire;
    logic             w_stall;

    assign w_retire = (state_q == ST_HOLD) && instr_ready;
    assign w_stall  = ((state_q == ST_REQ) && !imem_ack) ||
                      ((state_q == ST_HOLD) && !instr_ready);

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge CLK) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (w_retire && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
            if (w_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Directed self-checking bench for instr_fetch (RESET_PC=0x100, TIMEOUT=16)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        uncond_branch;
    logic        zero;
    logic [63:0] signext_imm;
    logic [63:0] pc;
    logic        fetch_err;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    instr_fetch #(
        .RESET_PC (64'h100),
        .TIMEOUT  (16),
        .CNT_W    (32)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch        (branch),
        .uncond_branch (uncond_branch),
        .zero          (zero),
        .signext_imm   (signext_imm),
        .pc            (pc),
        .fetch_err     (fetch_err)
`ifdef INSTR_FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        imem_rdata    = 32'h0;
        imem_ack      = 1'b0;
        instr_ready   = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        zero          = 1'b0;
        signext_imm   = 64'h0;

        // Reset state
        tick(); tick();
        chk("rst_req",   64'(imem_req),    64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_err",   64'(fetch_err),   64'd0);
        chk("rst_pc",    pc,               64'h100);
        chk("rst_instr", 64'(instr),       64'h0);
        chk("rst_opc",   64'(opcode),      64'h0);

        // Sequential fetch stream
        reset = 1'b0;
        tick();
        chk("seq_req0",  64'(imem_req), 64'd1);
        chk("seq_addr0", imem_addr,     64'h100);
        imem_ack = 1'b1; imem_rdata = 32'h8B020020;
        tick();
        chk("seq_valid0", 64'(instr_valid), 64'd1);
        chk("seq_instr0", 64'(instr),       64'h8B020020);
        chk("seq_opc0",   64'(opcode),      64'h458);
        chk("seq_hreq0",  64'(imem_req),    64'd0);
        imem_ack = 1'b0; instr_ready = 1'b1;
        tick();
        chk("seq_addr1",  imem_addr,        64'h104);
        chk("seq_valid1", 64'(instr_valid), 64'd0);
        imem_ack = 1'b1;
        tick();
        chk("seq_valid2", 64'(instr_valid), 64'd1);
        imem_ack = 1'b0;
        tick();
        chk("seq_addr2", imem_addr, 64'h108);

        // Conditional branch taken: 0x108 + (-2<<2) = 0x100
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        branch = 1'b1; zero = 1'b1; signext_imm = -64'sd2;
        tick();
        chk("cbz_taken", imem_addr, 64'h100);
        // Not taken with zero=0: 0x100 + 4
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        zero = 1'b0;
        tick();
        chk("cbz_not", imem_addr, 64'h104);
        // Unconditional: 0x104 + (0x10<<2) = 0x144
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        branch = 1'b0; uncond_branch = 1'b1; signext_imm = 64'h10;
        tick();
        chk("uncond", imem_addr, 64'h144);
        // Unknown branch control treated as not taken: 0x148
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        uncond_branch = 1'b0; branch = 1'bx; zero = 1'b1;
        tick();
        chk("x_branch", imem_addr, 64'h148);
        branch = 1'b0; zero = 1'b0; instr_ready = 1'b0;

        // Ack withheld 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("wait_req",  64'(imem_req), 64'd1);
            chk("wait_addr", imem_addr,     64'h148);
            tick();
        end
        chk("wait_err", 64'(fetch_err), 64'd0);
        imem_ack = 1'b1; imem_rdata = 32'hF84003E0;
        chk("wait_vpre", 64'(instr_valid), 64'd0);
        tick();
        chk("wait_valid", 64'(instr_valid), 64'd1);
        chk("wait_opc",   64'(opcode),      64'h7C2);

        // Stall in HOLD with spurious acks
        for (int i = 0; i < 10; i++) begin
            imem_ack   = i[0];
            imem_rdata = 32'hDEAD0000 + 32'(i);
            tick();
            chk("hold_instr", 64'(instr),       64'hF84003E0);
            chk("hold_pc",    pc,               64'h148);
            chk("hold_req",   64'(imem_req),    64'd0);
            chk("hold_valid", 64'(instr_valid), 64'd1);
        end
        imem_ack = 1'b0; instr_ready = 1'b1;
        tick();
        chk("hold_next", imem_addr, 64'h14C);
        instr_ready = 1'b0;

        // Reset in the middle of a request
        reset = 1'b1;
        tick();
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_pc",  pc,            64'h100);
        reset = 1'b0;
        tick();
        chk("mid_rst_addr", imem_addr, 64'h100);

        // Branch to 0x100 + (-65<<2) = 0xFFFF_FFFF_FFFF_FFFC, then wrap to 0
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        instr_ready = 1'b1; uncond_branch = 1'b1; signext_imm = -64'sd65;
        tick();
        chk("wrap_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        uncond_branch = 1'b0;
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        tick();
        chk("wrap_zero", imem_addr, 64'h0);
        instr_ready = 1'b0;

        // Timeout: 16 REQ cycles without ack, ERR on the 17th
        for (int i = 1; i < 16; i++) begin
            chk("tmo_req", 64'(imem_req), 64'd1);
            tick();
        end
        chk("tmo_req16", 64'(imem_req),  64'd1);
        chk("tmo_err16", 64'(fetch_err), 64'd0);
        tick();
        chk("tmo_err17", 64'(fetch_err), 64'd1);
        chk("tmo_req17", 64'(imem_req),  64'd0);
        imem_ack = 1'b1; imem_rdata = 32'h12345678;
        tick(); tick();
        imem_ack = 1'b0;
        chk("late_err",   64'(fetch_err),   64'd1);
        chk("late_valid", 64'(instr_valid), 64'd0);
        chk("late_req",   64'(imem_req),    64'd0);
        reset = 1'b1;
        tick();
        chk("err_clear", 64'(fetch_err), 64'd0);
        reset = 1'b0;
        tick();
        chk("err_restart", 64'(imem_req), 64'd1);

`ifdef INSTR_FETCH_PERF_CNT_EN
        // Three fetches, each with two ack-wait cycles
        reset = 1'b1; tick();
        chk("cnt_rst_f", 64'(fetch_cnt), 64'd0);
        chk("cnt_rst_s", 64'(stall_cnt), 64'd0);
        reset = 1'b0; instr_ready = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b0; tick(); tick();
            imem_ack = 1'b1; tick();
            imem_ack = 1'b0; tick();
        end
        chk("cnt_fetch", 64'(fetch_cnt), 64'd3);
        chk("cnt_stall", 64'(stall_cnt), 64'd6);
        instr_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
